cb_agd_burst: RTL
=================

# cb_agd_burst

Burst-capable, parametrised address generator for the covariance buffer (CB). It accepts a (row, col, length, direction) request and streams one CB word address per cycle for a run of matrix elements along a row or a column. Storage is lower-triangular by group: rows are grouped in blocks of 2^GROUP_SHIFT, and group k stores rows k·G..k·G+G−1 with (k+1)·G columns each. Optional symmetric folding maps upper-triangle coordinates onto stored lower-triangle words. It sits between the EKF update sequencer and the CB RAM address port.

## Interface
- CB_AW, 20: output address width.
- ROW_LEN, 10: row/col coordinate width.
- GROUP_SHIFT, 3: log2 of group size G (G = 8 by default).
- BL_W, 6: burst length field width.
- MAX_ROW, 1003: number of valid rows/cols (3 + 2·500 landmarks).
- clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid && ready.
- req_row  in  ROW_LEN  start row.
- req_col  in  ROW_LEN  start col.
- req_len  in  BL_W  burst length minus 1 (1..2^BL_W elements).
- req_dir  in  1  0: col increments; 1: row increments.
- req_sym  in  1  1: fold col>row by swapping row/col.
- addr_valid  out  1  CB_addr valid.
- addr_ready  in  1  downstream accepts CB_addr.
- CB_addr  out  CB_AW  word address.
- addr_last  out  1  final element of the burst.
- addr_err  out  1  element out of range (address still emitted).
- busy  out  1  FSM in BURST or any pipeline stage valid.

## Operation
- FSM has 2 states, IDLE and BURST. req_ready = (state==IDLE) && !stall, where stall = addr_valid && !addr_ready.
- Accept in IDLE: the FSM latches row, col, dir, sym and cnt = req_len, then moves to BURST.
- In BURST, each enabled cycle issues one element (row, col, last = (cnt==0)) into stage S1. It then advances the coordinate: col+1 if dir=0, row+1 if dir=1, and decrements cnt. After issuing last it returns to IDLE.
- Coordinates wrap mod 2^ROW_LEN. A wrapped element carries err.
- S1: if sym && col>row, swap row/col. Then k = row>>GROUP_SHIFT and idx = row[GROUP_SHIFT-1:0]. err |= (row≥MAX_ROW) || (col≥MAX_ROW) || (col ≥ (k+1)<<GROUP_SHIFT).
- S2: tri = k·(k+1)/2 (the product is always even; shift right 1) and roff = idx·(k+1).
- S3: base = tri<<(2·GROUP_SHIFT), rowoff = roff<<GROUP_SHIFT, col carried forward.
- OUT: CB_addr = base + rowoff + col, truncated to CB_AW. valid, last and err are carried alongside.
- Worked examples (G=8): (0,0)→0; (9,3)→83; (17,20)→236; (3,9) with sym=1→83.
- Stall: when stall=1, the FSM, all stages and the outputs hold. Bubbles are not collapsed.
- Reset (asynchronous, any time): state=IDLE, all stage valids=0, cnt=0, addr_valid=0, CB_addr=0, addr_last=0, addr_err=0, busy=0. An in-flight burst is discarded.

## Timing
- Request accepted at edge E0. Element i appears on CB_addr/addr_valid in the cycle after edge E0+4+i, assuming no stalls.
- Throughput is 1 address/cycle within a burst.
- req_ready is low from the cycle after acceptance until the cycle after last is issued. This gives a minimum 1-cycle bubble between consecutive bursts.
- Each stall cycle adds exactly one cycle to every element still in flight. Outputs are stable while stalled.
- addr_last is asserted only with addr_valid. busy deasserts the cycle after the last element is taken.

## Test plan
- Single element: row=9, col=3, len=0, dir=0, sym=0 → one beat CB_addr=83, addr_last=1, err=0, 5 cycles after accept.
- Row burst: row=17, col=16, len=7, dir=0 → 8 consecutive beats with addresses 232..239, last on beat 8, req_ready low throughout.
- Column burst with fold: row=0, col=9, len=3, dir=1, sym=1 → elements (9,0),(9,1),(9,2),(9,3) → addresses 80,81,82,83.
- Range error: row=3, col=9, sym=0 → addr_err=1 (col ≥ 8). row=1003, col=0 → addr_err=1. Both addresses are still emitted.
- Backpressure: 4-beat burst with addr_ready held low for 3 cycles at beat 2 → CB_addr holds beat-2 value, no beat lost or duplicated, total duration +3 cycles.
- Mid-burst reset: assert sys_rst_n=0 during beat 3 of 8 → addr_valid=0 and busy=0 immediately. After release, a new request (0,0,len=0) → CB_addr=0 with no stale beats.

Source files
------------

// File: rtl/cb_agd_burst_if.sv
// Request/address handshake bundle for the covariance-buffer burst address generator.
`timescale 1ns/1ps
interface cb_agd_burst_if #(
  parameter int unsigned CB_AW   = 20,
  parameter int unsigned ROW_LEN = 10,
  parameter int unsigned BL_W    = 6
);
  logic               req_valid;
  logic               req_ready;
  logic [ROW_LEN-1:0] req_row;
  logic [ROW_LEN-1:0] req_col;
  logic [BL_W-1:0]    req_len;
  logic               req_dir;
  logic               req_sym;
  logic               addr_valid;
  logic               addr_ready;
  logic [CB_AW-1:0]   CB_addr;
  logic               addr_last;
  logic               addr_err;
  logic               busy;

  modport master (
    output req_valid, req_row, req_col, req_len, req_dir, req_sym, addr_ready,
    input  req_ready, addr_valid, CB_addr, addr_last, addr_err, busy
  );

  modport slave (
    input  req_valid, req_row, req_col, req_len, req_dir, req_sym, addr_ready,
    output req_ready, addr_valid, CB_addr, addr_last, addr_err, busy
  );
endinterface

// File: rtl/cb_agd_burst.sv
// Burst address generator for the group-lower-triangular covariance buffer:
// one CB word address per cycle along a row or column, 4-stage pipeline.
`timescale 1ns/1ps
module cb_agd_burst #(
  parameter int unsigned CB_AW       = 20,
  parameter int unsigned ROW_LEN     = 10,
  parameter int unsigned GROUP_SHIFT = 3,
  parameter int unsigned BL_W        = 6,
  parameter int unsigned MAX_ROW     = 1003
) (
  input logic            clk,
  input logic            sys_rst_n,
  cb_agd_burst_if.slave  bus
);
  localparam int unsigned KW = ROW_LEN - GROUP_SHIFT;
  localparam logic [ROW_LEN:0] MAXR = (ROW_LEN+1)'(MAX_ROW);

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q;
  logic [ROW_LEN-1:0] row_q, col_q;
  logic [BL_W-1:0]    cnt_q;
  logic               dir_q, sym_q, wrap_q;

  logic               stall, en, issue;

  logic               s1_valid_q, s1_last_q, s1_err_q;
  logic [KW-1:0]      s1_k_q;
  logic [GROUP_SHIFT-1:0] s1_idx_q;
  logic [ROW_LEN-1:0] s1_col_q;

  logic               s2_valid_q, s2_last_q, s2_err_q;
  logic [CB_AW-1:0]   s2_tri_q, s2_roff_q;
  logic [ROW_LEN-1:0] s2_col_q;

  logic               s3_valid_q, s3_last_q, s3_err_q;
  logic [CB_AW-1:0]   s3_base_q, s3_rowoff_q;
  logic [ROW_LEN-1:0] s3_col_q;

  logic               out_valid_q, out_last_q, out_err_q;
  logic [CB_AW-1:0]   out_addr_q;

  logic [ROW_LEN-1:0] s1_row_d, s1_col_d;
  logic [KW-1:0]      s1_k_d;
  logic [GROUP_SHIFT-1:0] s1_idx_d;
  logic [ROW_LEN:0]   s1_lim_d;
  logic               s1_err_d;
  logic [CB_AW-1:0]   s2_kx_d, s2_tri_d, s2_roff_d;
  logic [CB_AW-1:0]   s3_base_d, s3_rowoff_d, out_addr_d;

  assign stall = out_valid_q && !bus.addr_ready;
  assign en    = !stall;
  assign issue = (state_q == BURST);

  assign bus.req_ready  = (state_q == IDLE) && !stall;
  assign bus.addr_valid = out_valid_q;
  assign bus.CB_addr    = out_addr_q;
  assign bus.addr_last  = out_last_q;
  assign bus.addr_err   = out_err_q;
  assign bus.busy       = issue || s1_valid_q || s2_valid_q || s3_valid_q || out_valid_q;

  // Fold into the lower triangle first so the group bound is checked on stored coordinates.
  always_comb begin
    s1_row_d = row_q;
    s1_col_d = col_q;
    if (sym_q && (col_q > row_q)) begin
      s1_row_d = col_q;
      s1_col_d = row_q;
    end
    s1_k_d   = s1_row_d[ROW_LEN-1:GROUP_SHIFT];
    s1_idx_d = s1_row_d[GROUP_SHIFT-1:0];
    s1_lim_d = ({{(GROUP_SHIFT+1){1'b0}}, s1_k_d} + (ROW_LEN+1)'(1)) << GROUP_SHIFT;
    s1_err_d = wrap_q || ({1'b0, s1_row_d} >= MAXR) || ({1'b0, s1_col_d} >= MAXR)
               || ({1'b0, s1_col_d} >= s1_lim_d);
  end

  always_comb begin
    s2_kx_d     = CB_AW'(s1_k_q);
    s2_tri_d    = (s2_kx_d * (s2_kx_d + CB_AW'(1))) >> 1;
    s2_roff_d   = CB_AW'(s1_idx_q) * (s2_kx_d + CB_AW'(1));
    s3_base_d   = s2_tri_q << (2 * GROUP_SHIFT);
    s3_rowoff_d = s2_roff_q << GROUP_SHIFT;
    out_addr_d  = s3_base_q + s3_rowoff_q + CB_AW'(s3_col_q);
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sym_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            row_q   <= bus.req_row;
            col_q   <= bus.req_col;
            cnt_q   <= bus.req_len;
            dir_q   <= bus.req_dir;
            sym_q   <= bus.req_sym;
            wrap_q  <= 1'b0;
            state_q <= BURST;
          end
        end
        BURST: begin
          // wrap_q is sticky so every element past the wrap point is flagged.
          if (dir_q) begin
            row_q <= row_q + ROW_LEN'(1);
            if (&row_q) wrap_q <= 1'b1;
          end else begin
            col_q <= col_q + ROW_LEN'(1);
            if (&col_q) wrap_q <= 1'b1;
          end
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - BL_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_k_q      <= '0;
      s1_idx_q    <= '0;
      s1_col_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_tri_q    <= '0;
      s2_roff_q   <= '0;
      s2_col_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_err_q    <= 1'b0;
      s3_base_q   <= '0;
      s3_rowoff_q <= '0;
      s3_col_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      out_addr_q  <= '0;
    end else if (en) begin
      s1_valid_q  <= issue;
      s1_last_q   <= issue && (cnt_q == '0);
      s1_err_q    <= issue && s1_err_d;
      s1_k_q      <= s1_k_d;
      s1_idx_q    <= s1_idx_d;
      s1_col_q    <= s1_col_d;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_err_q    <= s1_err_q;
      s2_tri_q    <= s2_tri_d;
      s2_roff_q   <= s2_roff_d;
      s2_col_q    <= s1_col_q;
      s3_valid_q  <= s2_valid_q;
      s3_last_q   <= s2_last_q;
      s3_err_q    <= s2_err_q;
      s3_base_q   <= s3_base_d;
      s3_rowoff_q <= s3_rowoff_d;
      s3_col_q    <= s2_col_q;
      out_valid_q <= s3_valid_q;
      out_last_q  <= s3_last_q;
      out_err_q   <= s3_err_q;
      out_addr_q  <= out_addr_d;
    end
  end
endmodule
